asynchronous_fifo: RTL and testbench

Dual-clock FIFO for moving WIDTH-bit words from a write clock domain (wr_clk) to an unrelated read clock domain (rd_clk). Gray-coded pointers are exchanged through two-flop synchronizers, so full and empty are always safe (conservative) flags. It sits at any clock-domain boundary where a producer runs faster than, or asynchronously to, its consumer.

---
 rtl/asynchronous_fifo.sv | 90 +++++++++
 tb/tb_asynchronous_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/asynchronous_fifo.sv
// Dual-clock FIFO: Gray-coded pointers cross domains through two-flop synchronizers,
// so full and empty are conservative in their own domains.
module asynchronous_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             wr_clk,
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t wbin_q, wgray_q, rsync1_q, rsync2_q;
  ptr_t wbin_d, wgray_d;
  ptr_t rbin_q, rgray_q, wsync1_q, wsync2_q;
  ptr_t rbin_d, rgray_d;
  logic full_q, empty_q;
  logic write_ok, read_ok;
  logic [WIDTH-1:0] read_data_q;

  assign write_ok = write_en & ~full_q;
  assign read_ok  = read_en & ~empty_q;

  always_comb begin
    wbin_d  = wbin_q + ptr_t'(write_ok);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    rbin_d  = rbin_q + ptr_t'(read_ok);
    rgray_d = rbin_d ^ (rbin_d >> 1);
  end

  // Write domain: pointers, read-pointer synchronizer and full flag.
  always_ff @(posedge wr_clk) begin
    if (!reset) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rsync1_q <= rgray_q;
      rsync2_q <= rsync1_q;
      // Full when the write pointer is one lap ahead: Gray form flips the top two bits.
      full_q   <= (wgray_d == {~rsync2_q[AW:AW-1], rsync2_q[AW-2:0]});
    end
  end

  always_ff @(posedge wr_clk) begin
    if (write_ok) begin
      mem[wbin_q[AW-1:0]] <= write_data;
    end
  end

  // Read domain: pointers, write-pointer synchronizer, empty flag and output register.
  always_ff @(posedge rd_clk) begin
    if (!reset) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      wsync1_q    <= '0;
      wsync2_q    <= '0;
      empty_q     <= 1'b1;
      read_data_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      wsync1_q <= wgray_q;
      wsync2_q <= wsync1_q;
      empty_q  <= (rgray_d == wsync2_q);
      if (read_ok) begin
        read_data_q <= mem[rbin_q[AW-1:0]];
      end
    end
  end

  assign read_data = read_data_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Bench for asynchronous_fifo: a queue model tracks accepted words across both clocks
// while a directed sequence plus a randomized phase drives the ports.
module tb_asynchronous_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             wr_clk = 1'b0;
  logic             rd_clk = 1'b0;
  logic             reset = 1'b0;
  logic             write_en = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic             read_en = 1'b0;
  logic [WIDTH-1:0] read_data;
  logic             full;
  logic             empty;

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int n0;
  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] last_rd = '0;

  asynchronous_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .wr_clk    (wr_clk),
    .rd_clk    (rd_clk),
    .reset     (reset),
    .write_en  (write_en),
    .write_data(write_data),
    .read_en   (read_en),
    .read_data (read_data),
    .full      (full),
    .empty     (empty)
  );

  always #5 wr_clk = ~wr_clk;
  initial begin
    #3;
    forever #10 rd_clk = ~rd_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-side model: a word is stored exactly when write_en is high and full is low.
  always @(posedge wr_clk) begin
    if (!reset) model.delete();
    else if (write_en && !full) model.push_back(write_data);
    #1;
    if (model.size() >= DEPTH) check("full_safe", {31'b0, full}, 32'd1);
  end

  // Read-side model: every accepted read returns the oldest stored word; otherwise hold.
  always @(posedge rd_clk) begin
    if (!reset) begin
      model.delete();
      last_rd = '0;
    end else if (read_en && !empty) begin
      check("pop_nonempty", {31'b0, model.size() != 0}, 32'd1);
      if (model.size() != 0) last_rd = model.pop_front();
      n_reads++;
    end
    #1;
    check("read_data", {24'b0, read_data}, {24'b0, last_rd});
    if (model.size() == 0) check("empty_safe", {31'b0, empty}, 32'd1);
  end

  task automatic write_word(input logic [WIDTH-1:0] d);
    @(negedge wr_clk);
    write_en   = 1'b1;
    write_data = d;
    @(negedge wr_clk);
    write_en = 1'b0;
  endtask

  task automatic wait_not_empty();
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      if (!empty) break;
    end
    check("empty_release", {31'b0, empty}, 32'd0);
  endtask

  task automatic drain(input int budget);
    @(negedge rd_clk);
    read_en = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge rd_clk);
      if (empty && model.size() == 0) break;
    end
    read_en = 1'b0;
    check("drain_done", model.size(), 32'd0);
    check("drain_empty", {31'b0, empty}, 32'd1);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge rd_clk);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_data", {24'b0, read_data}, 32'd0);
    @(negedge wr_clk);
    reset = 1'b1;

    // Fill 01..08, then 09 is dropped
    for (int i = 1; i <= 9; i++) begin
      @(negedge wr_clk);
      write_en   = 1'b1;
      write_data = WIDTH'(i);
      if (i == 9) check("fill_full", {31'b0, full}, 32'd1);
    end
    @(negedge wr_clk);
    write_en = 1'b0;
    check("fill_count", model.size(), 32'd8);
    check("fill_full_hold", {31'b0, full}, 32'd1);

    // Drain
    repeat (3) @(negedge rd_clk);
    n0 = n_reads;
    drain(20);
    check("drain_count", n_reads - n0, 32'd8);
    check("drain_last", {24'b0, read_data}, 32'h08);
    check("drain_full_off", {31'b0, full}, 32'd0);

    // Streaming wrap
    n0 = n_reads;
    fork
      begin : writer
        logic [WIDTH-1:0] cnt;
        cnt = 8'h0A;
        for (int i = 0; i < 60; i++) begin
          @(negedge wr_clk);
          write_en   = 1'b1;
          write_data = cnt;
          @(posedge wr_clk);
          if (!full) cnt++;
        end
        @(negedge wr_clk);
        write_en = 1'b0;
      end
      begin : reader
        @(negedge rd_clk);
        read_en = 1'b1;
        repeat (30) @(negedge rd_clk);
        read_en = 1'b0;
      end
    join
    check("stream_reads", {31'b0, (n_reads - n0) > 16}, 32'd1);
    drain(30);

    // Underflow: reads on an empty FIFO must not disturb read_data
    @(negedge rd_clk);
    read_en = 1'b1;
    repeat (5) @(negedge rd_clk);
    read_en = 1'b0;
    check("underflow_hold", {24'b0, read_data}, {24'b0, last_rd});
    write_word(8'hA5);
    wait_not_empty();
    drain(10);
    check("underflow_a5", {24'b0, read_data}, 32'hA5);

    // Randomized traffic with a slow reader so full is exercised
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          @(negedge wr_clk);
          write_en   = ($urandom_range(0, 3) != 0);
          write_data = WIDTH'($urandom);
        end
        @(negedge wr_clk);
        write_en = 1'b0;
      end
      begin
        for (int i = 0; i < 75; i++) begin
          @(negedge rd_clk);
          read_en = ($urandom_range(0, 2) == 0);
        end
        @(negedge rd_clk);
        read_en = 1'b0;
      end
    join
    drain(40);

    // Reset mid-stream with four words stored
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      write_en   = 1'b1;
      write_data = WIDTH'(8'h11 + i);
    end
    @(negedge wr_clk);
    write_en = 1'b0;
    repeat (4) @(negedge rd_clk);
    check("mid_loaded", {31'b0, empty}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge rd_clk);
    check("mid_rst_empty", {31'b0, empty}, 32'd1);
    check("mid_rst_full", {31'b0, full}, 32'd0);
    check("mid_rst_data", {24'b0, read_data}, 32'd0);
    @(negedge wr_clk);
    reset = 1'b1;
    write_word(8'h3C);
    wait_not_empty();
    drain(10);
    check("mid_3c", {24'b0, read_data}, 32'h3C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
